// File: rtl/nmea_pkg.sv
// Shared constants, FSM states and hex decode for the NMEA sentence gate.
package nmea_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [2:0] {
        HUNT,
        BODY,
        CK_HI,
        CK_LO,
        EOL_CR,
        EOL_LF
    } state_t;

    // {valid, nibble}; only 0-9 and uppercase A-F are valid
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46)
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

endpackage

// File: rtl/nmea_commit_fifo.sv
// Circular byte buffer with speculative write, commit/discard and a
// registered first-word-fall-through output stage.
module nmea_commit_fifo
    import nmea_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       discard,
    output logic       full_wr,
    output logic       full_cm,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] base;
    logic [PW-1:0] wr_next;
    logic          load;

    // a discard with a write restarts the sentence at the commit point
    assign base    = discard ? cm_ptr : wr_ptr;
    assign wr_next = base + PW'(wr_en);
    assign full_wr = (wr_ptr - rd_ptr) == PW'(DEPTH - 1);
    assign full_cm = (cm_ptr - rd_ptr) == PW'(DEPTH - 1);
    assign load    = (rd_ptr != cm_ptr) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[base[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            rd_ptr    <= '0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            if (commit)
                cm_ptr <= wr_next;
            if (load) begin
                out_data  <= mem[rd_ptr[AW-1:0]];
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + PW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nmea_sentence_gate.sv
// Releases only complete, checksum-valid NMEA sentences downstream.
// Define NMEA_REQUIRE_CHECKSUM_EN to reject sentences without *hh.
module nmea_sentence_gate
    import nmea_pkg::*;
#(
    parameter int BUF_DEPTH = 128,
    parameter int MAX_LEN   = 82
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sent_ok,
    output logic       sent_bad,
    output logic       overflow
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t        state;
    state_t        state_n;
    state_t        nxt;
    logic [7:0]    xor_acc;
    logic [7:0]    xor_n;
    logic [7:0]    ck;
    logic [7:0]    ck_n;
    logic [LW-1:0] len;
    logic [LW-1:0] len_n;
    logic          raw;
    logic          raw_n;
    logic          good;
    logic          fin;
    logic          wr_en;
    logic          commit;
    logic          discard;
    logic          full_wr;
    logic          full_cm;
    logic          ok_n;
    logic          bad_n;
    logic          ovf_n;
    logic [4:0]    hex;

    assign hex = hex_decode(rx_data);

    always_comb begin
        state_n = state;
        nxt     = state;
        xor_n   = xor_acc;
        ck_n    = ck;
        len_n   = len;
        raw_n   = raw;
        good    = 1'b0;
        fin     = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        discard = 1'b0;
        ok_n    = 1'b0;
        bad_n   = 1'b0;
        ovf_n   = 1'b0;
        if (rx_valid) begin
            if (rx_data == CH_DOLLAR) begin
                discard = (state != HUNT);
                if (full_cm) begin
                    discard = 1'b1;
                    ovf_n   = 1'b1;
                    state_n = HUNT;
                end else begin
                    wr_en   = 1'b1;
                    xor_n   = 8'd0;
                    ck_n    = 8'd0;
                    len_n   = LW'(1);
                    raw_n   = 1'b0;
                    state_n = BODY;
                end
            end else if (state != HUNT) begin
                unique case (state)
                    BODY: begin
                        good = 1'b1;
                        if (rx_data == CH_STAR) begin
                            nxt = CK_HI;
                        end else if (rx_data == CH_CR) begin
`ifdef NMEA_REQUIRE_CHECKSUM_EN
                            good = 1'b0;
`else
                            nxt   = EOL_LF;
                            raw_n = 1'b1;
`endif
                        end else begin
                            nxt   = BODY;
                            xor_n = xor_acc ^ rx_data;
                        end
                    end
                    CK_HI: begin
                        good = hex[4];
                        ck_n = {ck[3:0], hex[3:0]};
                        nxt  = CK_LO;
                    end
                    CK_LO: begin
                        good = hex[4];
                        ck_n = {ck[3:0], hex[3:0]};
                        nxt  = EOL_CR;
                    end
                    EOL_CR: begin
                        good = (rx_data == CH_CR);
                        nxt  = EOL_LF;
                    end
                    EOL_LF: begin
                        good = (rx_data == CH_LF);
                        nxt  = HUNT;
                        fin  = 1'b1;
                    end
                    default: ;
                endcase
                // a mismatched LF is rejected before it is written
                if (!good || len == LW'(MAX_LEN) ||
                    (fin && !raw && ck != xor_acc)) begin
                    discard = 1'b1;
                    bad_n   = 1'b1;
                    state_n = HUNT;
                end else if (full_wr) begin
                    discard = 1'b1;
                    ovf_n   = 1'b1;
                    state_n = HUNT;
                end else begin
                    wr_en   = 1'b1;
                    len_n   = len + LW'(1);
                    state_n = nxt;
                    commit  = fin;
                    ok_n    = fin;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            xor_acc  <= 8'd0;
            ck       <= 8'd0;
            len      <= '0;
            raw      <= 1'b0;
            sent_ok  <= 1'b0;
            sent_bad <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            xor_acc  <= xor_n;
            ck       <= ck_n;
            len      <= len_n;
            raw      <= raw_n;
            sent_ok  <= ok_n;
            sent_bad <= bad_n;
            overflow <= ovf_n;
        end
    end

    nmea_commit_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (rx_data),
        .commit   (commit),
        .discard  (discard),
        .full_wr  (full_wr),
        .full_cm  (full_cm),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: doc/nmea_sentence_gate.md
# nmea_sentence_gate

Byte-stream filter between `uart_rx` and the NMEA parsers (`gprmc_parser`, `gprmc_fix_detector`). It buffers each incoming NMEA sentence and verifies the XOR checksum. Only complete, checksum-valid sentences are released downstream, so the parsers never see corrupted or truncated sentences.

## Interface
Parameters:
- `BUF_DEPTH`, 128: sentence buffer depth in bytes; must be a power of 2.
- `MAX_LEN`, 82: maximum sentence length, counting `$` through LF.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte from `uart_rx`.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `out_data`  out  8  released byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the byte; a transfer occurs when `out_valid && out_ready`.
- `sent_ok`  out  1  one-cycle pulse when a sentence is committed.
- `sent_bad`  out  1  one-cycle pulse when a sentence is discarded for checksum, format or length.
- `overflow`  out  1  one-cycle pulse when a sentence is discarded because the buffer is full.

## Operation
- The buffer is circular and uses three pointers:
  - `wr_ptr`: speculative write position.
  - `cm_ptr`: end of committed data.
  - `rd_ptr`: read position.
- Commit sets `cm_ptr <= wr_ptr`. Discard sets `wr_ptr <= cm_ptr`.
- FSM states: `HUNT`, `BODY`, `CK_HI`, `CK_LO`, `EOL_CR`, `EOL_LF`. All transitions happen only on `rx_valid`.
- `HUNT`:
  - `$` (0x24): write it, clear `xor_acc` and `len`, go to `BODY`.
  - Any other byte is ignored.
- `BODY`:
  - `*` (0x2A): write it, go to `CK_HI`.
  - Any other byte: write it and update `xor_acc ^= byte`.
- `CK_HI` / `CK_LO`:
  - Accept only `0-9` and `A-F`; lowercase or any other character counts as bad.
  - Write the byte and shift it into `ck[7:0]`.
  - After `CK_LO`, go to `EOL_CR`.
- `EOL_CR`: expect CR (0x0D), write it, go to `EOL_LF`.
- `EOL_LF`: expect LF (0x0A), write it.
  - If `ck == xor_acc`, commit and pulse `sent_ok`.
  - Otherwise discard and pulse `sent_bad`.
  - Either way, return to `HUNT`.
- `$` received in any non-`HUNT` state: discard the partial sentence (no pulse), then restart as if in `HUNT`.
- Unexpected byte in `CK_*` or `EOL_*`: discard, pulse `sent_bad`, go to `HUNT`.
- Length limit: `len` counts written bytes. A byte that would make `len > MAX_LEN` triggers discard, `sent_bad`, and a return to `HUNT`.
- Buffer full: if a write would make `wr_ptr + 1 == rd_ptr`, discard, pulse `overflow`, go to `HUNT`, and drop the byte. Committed data is never overwritten.
- Pointers are `$clog2(BUF_DEPTH)+1` bits wide and wrap modulo 2×depth. Empty is `rd_ptr == cm_ptr`.
- The gate never back-pressures its input; every `rx_valid` byte is consumed in the cycle it arrives.

## Timing
- Reset values:
  - All outputs 0.
  - Pointers, `len`, `xor_acc` and `ck` all 0.
  - FSM in `HUNT`.
  - Buffer contents are don't-care.
- Reset asserted mid-sentence or mid-readout loses all data, both partial and committed.
- Commit and the status pulses register one cycle after the LF `rx_valid`. Call that cycle N+1.
- First `out_valid` is asserted at N+2. `out_data` comes from a registered first-word-fall-through stage.
- Readout streams back-to-back at 1 byte/cycle while `out_ready` is held high.
- `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- A commit and a read in the same cycle are both honoured.
- `sent_ok`, `sent_bad` and `overflow` are mutually exclusive within a cycle.

## Configuration
- `NMEA_REQUIRE_CHECKSUM_EN` defined: a CR received in `BODY` counts as bad (discard and `sent_bad`); a checksum is mandatory.
- `NMEA_REQUIRE_CHECKSUM_EN` undefined: a CR received in `BODY` is written and goes to `EOL_LF`. On LF the sentence commits unconditionally and `sent_ok` pulses.

## Structure
- Package `nmea_pkg`:
  - ASCII constants: `$`, `*`, CR, LF.
  - FSM state enum.
  - Hex-digit decode function.
- Sub-module `nmea_commit_fifo`: circular RAM with the write/commit/discard/read pointers and the registered output stage.
- The gate itself holds the FSM, `xor_acc`, `ck` and `len`.

## Test plan
- `$GPA*56\r\n` (0x47^0x50^0x41 = 0x56): all 9 bytes are released in order, `sent_ok` pulses once, first `out_valid` appears 2 cycles after the LF.
- `$GPA*57\r\n`: no output, `sent_bad` pulses once, `out_valid` stays 0.
- `$GP$GPA*56\r\n`: the first partial is dropped silently and only `$GPA*56\r\n` is released.
- 90-byte body after `$`: `sent_bad` pulses at byte 83, nothing is released, and a following valid sentence passes.
- `out_ready` held 0 across 2 valid 9-byte sentences with `BUF_DEPTH=16`: the first commits, the second gets an `overflow` pulse. After `out_ready` rises, exactly the first 9 bytes drain.
- `$GPA\r\n`: rejected with `sent_bad` when `NMEA_REQUIRE_CHECKSUM_EN` is defined; released with `sent_ok` when it is undefined.
